sha256_sched_ctrl: RTL and testbench

Sequencer and port arbiter for the 64x32 message-schedule register file of the SHA-256 core.
- Loads W[0..15] from an input stream.
- Expands W[16..63] in place through the register file's single combinational read port and single write port.
- Then hands the read port to the compression round engine until released.
- W[t] is always stored at register address t.

---
 rtl/sha256_sched_ctrl.sv | 101 ++++++++++
 tb/tb_sha256_sched_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sha256_sched_ctrl.sv
// sha256_sched_ctrl: SHA-256 message schedule sequencer and register-file port arbiter.
// Optional cycle counter output perf_cycles enabled by defining SCHED_PERF_CNT_EN.
module sha256_sched_ctrl #(
  parameter int ADDR_W = 6,
  parameter int LOAD_WORDS = 16,
  parameter int LAST_WORD = 63
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  input  logic              engine_release,
  input  logic [ADDR_W-1:0] ext_raddr,
  output logic [31:0]       ext_rdata,
  output logic              done,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [31:0]       rf_rdata
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, E16 = 3'd2, E15 = 3'd3, E7 = 3'd4, E2 = 3'd5, DONE = 3'd6;
  logic [2:0] state;
  logic [6:0] t;
  logic [31:0] acc;
  logic [ADDR_W-1:0] ta;
  logic enter_load;
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  assign ta = t[ADDR_W-1:0];
  assign enter_load = start && (state == IDLE || state == DONE);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      t <= '0;
      acc <= '0;
    end else if (enter_load) begin
      state <= LOAD;
      t <= '0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          t <= t + 7'd1;
          if (t == 7'(LOAD_WORDS - 1)) state <= E16;
        end
        E16: begin
          acc <= rf_rdata;
          state <= E15;
        end
        E15: begin
          acc <= acc + sig0(rf_rdata);
          state <= E7;
        end
        E7: begin
          acc <= acc + rf_rdata;
          state <= E2;
        end
        E2: if (t == 7'(LAST_WORD)) state <= DONE;
        else begin
          t <= t + 7'd1;
          state <= E16;
        end
        DONE: if (engine_release) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // Loading reads one address ahead so the read port never aliases the write address.
  always_comb begin
    in_ready = state == LOAD;
    busy = state >= LOAD && state <= E2;
    done = state == DONE;
    rf_we = !reset && ((in_ready && in_valid) || state == E2);
    rf_waddr = rf_we ? ta : '0;
    rf_wdata = !rf_we ? '0 : in_ready ? in_data : acc + sig1(rf_rdata);
    rf_raddr = state == LOAD ? ta + ADDR_W'(1) :
               state == E16  ? ta - ADDR_W'(16) :
               state == E15  ? ta - ADDR_W'(15) :
               state == E7   ? ta - ADDR_W'(7) :
               state == E2   ? ta - ADDR_W'(2) :
               done          ? ext_raddr : '0;
    ext_rdata = done ? rf_rdata : '0;
  end
`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset || enter_load) perf_cycles <= '0;
    else if (busy && perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 16'd1;
  end
`endif
endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// tb_sha256_sched_ctrl: randomized self-checking bench for sha256_sched_ctrl with a register-file model
// and a direct SHA-256 schedule reference; perf checks when SCHED_PERF_CNT_EN is defined.
module tb_sha256_sched_ctrl;
  logic clock = 0, reset = 1, start = 0, in_valid = 0, engine_release = 0;
  logic [31:0] in_data = 0;
  logic [5:0] ext_raddr = 0;
  logic in_ready, done, busy, rf_we;
  logic [31:0] ext_rdata, rf_wdata, rf_rdata;
  logic [5:0] rf_waddr, rf_raddr;
`ifdef SCHED_PERF_CNT_EN
  logic [15:0] perf_cycles;
`endif
  sha256_sched_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .engine_release(engine_release), .ext_raddr(ext_raddr), .ext_rdata(ext_rdata),
    .done(done), .busy(busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
`ifdef SCHED_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );
  always #5 clock = ~clock;
  logic [31:0] rf [64];
  assign rf_rdata = rf[rf_raddr];
  always @(posedge clock) if (rf_we) rf[rf_waddr] <= rf_wdata;
  logic [5:0] wa [$];
  logic [31:0] wd [$];
  always @(posedge clock) if (rf_we) begin wa.push_back(rf_waddr); wd.push_back(rf_wdata); end
  int n_cmp = 0, n_err = 0;
  logic [31:0] blk [16];
  logic [31:0] gold [64];
  logic [31:0] snap [64];
  int mode, pulse_at, abort_at, exp_cycles, load_cycles, stall_we, errs;
  bit do_start;
  logic abort_we;
  logic [5:0] abort_raddr;
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  task automatic build_gold();
    for (int i = 0; i < 16; i++) gold[i] = blk[i];
    for (int i = 16; i < 64; i++)
      gold[i] = (rotr(gold[i-2], 17) ^ rotr(gold[i-2], 19) ^ (gold[i-2] >> 10)) + gold[i-7]
              + (rotr(gold[i-15], 7) ^ rotr(gold[i-15], 18) ^ (gold[i-15] >> 3)) + gold[i-16];
  endtask
  task automatic rand_blk();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask
  // Drives one block; leaves the bench at posedge+1 with done high (or aborted/timed out).
  task automatic run_block();
    int i, c, k;
    build_gold();
    wa.delete(); wd.delete();
    stall_we = 0; exp_cycles = -1;
    if (do_start) begin
      @(negedge clock); start = 1;
      @(posedge clock); #1 start = 0;
    end
    i = 0; c = 0;
    while (i < 16 && c < 200) begin
      in_valid = (mode == 0) || (mode == 1 && c % 2 == 0) || (mode == 2 && !(c >= 3 && c < 8));
      in_data = in_valid ? blk[i] : $urandom;
      #1 if (!in_valid && rf_we) stall_we++;
      @(posedge clock);
      if (in_valid) i++;
      c++;
      #1;
    end
    in_valid = 0;
    load_cycles = c;
    k = 0;
    while (!done && k < 1000) begin
      if (k == abort_at) begin
        reset = 1;
        #1 abort_we = rf_we; abort_raddr = rf_raddr;
        @(posedge clock); #1 reset = 0;
        exp_cycles = -2;
        return;
      end
      if (k == pulse_at) start = 1;
      @(posedge clock); #1 start = 0;
      k++;
    end
    exp_cycles = done ? k : -1;
  endtask
  task automatic test_reset();
    reset = 1; ext_raddr = 6'd17;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if ({in_ready, done, busy, rf_we} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {in_ready, done, busy, rf_we}); end
    n_cmp++; if ({rf_waddr, rf_raddr} !== 12'h0) begin n_err++; $display("FAIL reset_addrs: got %h want 000", {rf_waddr, rf_raddr}); end
    n_cmp++; if ({rf_wdata, ext_rdata} !== 64'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", {rf_wdata, ext_rdata}); end
    @(negedge clock); reset = 0; engine_release = 1;
    @(negedge clock); engine_release = 0;
    n_cmp++; if ({in_ready, done, busy} !== 3'b0) begin n_err++; $display("FAIL idle_hold: got %b want 000", {in_ready, done, busy}); end
  endtask
  task automatic test_abc();
    for (int i = 0; i < 16; i++) blk[i] = 0;
    blk[0] = 32'h61626380; blk[15] = 32'h00000018;
    mode = 0; pulse_at = -1; abort_at = -1; do_start = 1;
    run_block();
    n_cmp++; if (load_cycles !== 16) begin n_err++; $display("FAIL abc_load_cycles: got %0d want 16", load_cycles); end
    n_cmp++; if (exp_cycles !== 192) begin n_err++; $display("FAIL abc_exp_cycles: got %0d want 192", exp_cycles); end
    n_cmp++; if (rf[16] !== 32'h61626380) begin n_err++; $display("FAIL abc_w16: got %h want 61626380", rf[16]); end
    n_cmp++; if (rf[17] !== 32'h000F0000) begin n_err++; $display("FAIL abc_w17: got %h want 000f0000", rf[17]); end
    n_cmp++; if (wa.size() !== 64) begin n_err++; $display("FAIL abc_write_count: got %0d want 64", wa.size()); end
    errs = 0;
    for (int i = 0; i < wa.size() && i < 64; i++) if (wa[i] !== 6'(i) || wd[i] !== gold[i]) errs++;
    n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL abc_write_seq: got %0d bad writes want 0", errs); end
    n_cmp++; if ({done, busy, in_ready} !== 3'b100) begin n_err++; $display("FAIL abc_done_flags: got %b want 100", {done, busy, in_ready}); end
  endtask
  task automatic test_sweep();
    errs = 0;
    for (int a = 0; a < 64; a++) begin
      ext_raddr = 6'(a);
      #1 if (ext_rdata !== gold[a] || rf_raddr !== 6'(a)) errs++;
    end
    n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL sweep_ext_rdata: got %0d bad reads want 0", errs); end
  endtask
  task automatic test_stall();
    rand_blk();
    mode = 0; do_start = 1; pulse_at = -1; abort_at = -1;
    run_block();
    for (int i = 0; i < 64; i++) snap[i] = rf[i];
    mode = 1;
    run_block();
    n_cmp++; if (stall_we !== 0) begin n_err++; $display("FAIL stall_we: got %0d stalled writes want 0", stall_we); end
    n_cmp++; if (load_cycles !== 31) begin n_err++; $display("FAIL stall_load_cycles: got %0d want 31", load_cycles); end
    n_cmp++; if (exp_cycles !== 192) begin n_err++; $display("FAIL stall_exp_cycles: got %0d want 192", exp_cycles); end
    errs = 0;
    for (int i = 0; i < wa.size() && i < 64; i++) if (wa[i] !== 6'(i)) errs++;
    for (int i = 0; i < 64; i++) if (rf[i] !== snap[i] || rf[i] !== gold[i]) errs++;
    n_cmp++; if (errs !== 0 || wa.size() !== 64) begin n_err++; $display("FAIL stall_schedule: got %0d bad words, %0d writes want 0, 64", errs, wa.size()); end
  endtask
  task automatic test_reset_mid();
    rand_blk();
    mode = 0; do_start = 1; pulse_at = -1; abort_at = 98;
    run_block();
    n_cmp++; if (abort_raddr !== 6'd33) begin n_err++; $display("FAIL abort_exp7_raddr: got %0d want 33", abort_raddr); end
    n_cmp++; if ({in_ready, rf_we, done, busy} !== 4'b0) begin n_err++; $display("FAIL abort_idle: got %b want 0000", {in_ready, rf_we, done, busy}); end
    n_cmp++; if (wa.size() !== 40) begin n_err++; $display("FAIL abort_writes: got %0d want 40", wa.size()); end
    abort_at = 3;
    run_block();
    n_cmp++; if (abort_we !== 1'b0 || wa.size() !== 16) begin n_err++; $display("FAIL abort_exp2_write: got we=%b writes=%0d want 0, 16", abort_we, wa.size()); end
    abort_at = -1; mode = 2;
    rand_blk();
    run_block();
    errs = 0;
    for (int i = 0; i < 64; i++) if (rf[i] !== gold[i]) errs++;
    n_cmp++; if (errs !== 0 || exp_cycles !== 192) begin n_err++; $display("FAIL after_abort_block: got %0d bad words, %0d cycles want 0, 192", errs, exp_cycles); end
  endtask
  task automatic test_start_release();
    @(negedge clock); start = 1; engine_release = 1;
    @(posedge clock); #1 start = 0; engine_release = 0;
    n_cmp++; if ({in_ready, busy, done} !== 3'b110) begin n_err++; $display("FAIL start_wins: got %b want 110", {in_ready, busy, done}); end
    rand_blk();
    mode = 0; do_start = 0; pulse_at = 50; abort_at = -1;
    run_block();
    n_cmp++; if (exp_cycles !== 192) begin n_err++; $display("FAIL start_ignored_cycles: got %0d want 192", exp_cycles); end
    errs = 0;
    for (int i = 0; i < 64; i++) if (rf[i] !== gold[i]) errs++;
    n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL start_ignored_data: got %0d bad words want 0", errs); end
    @(negedge clock); engine_release = 1;
    @(negedge clock); engine_release = 0;
    n_cmp++; if ({in_ready, busy, done, ext_rdata} !== 35'b0) begin n_err++; $display("FAIL release_idle: got %b %h want 000 0", {in_ready, busy, done}, ext_rdata); end
  endtask
  task automatic test_perf();
`ifdef SCHED_PERF_CNT_EN
    rand_blk();
    mode = 0; do_start = 1; pulse_at = -1; abort_at = -1;
    run_block();
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (perf_cycles !== 16'd208) begin n_err++; $display("FAIL perf_unstalled: got %0d want 208", perf_cycles); end
    mode = 2;
    run_block();
    n_cmp++; if (perf_cycles !== 16'd213) begin n_err++; $display("FAIL perf_stalled: got %0d want 213", perf_cycles); end
    @(negedge clock); engine_release = 1;
    @(negedge clock); engine_release = 0;
    repeat (2) @(negedge clock);
    n_cmp++; if (perf_cycles !== 16'd213) begin n_err++; $display("FAIL perf_idle_hold: got %0d want 213", perf_cycles); end
`endif
  endtask
  task automatic test_back_to_back();
    for (int b = 0; b < 3; b++) begin
      rand_blk();
      mode = int'($urandom_range(0, 2)); do_start = 1; pulse_at = -1; abort_at = -1;
      run_block();
      errs = 0;
      for (int i = 0; i < 64; i++) if (rf[i] !== gold[i]) errs++;
      n_cmp++; if (errs !== 0 || exp_cycles !== 192) begin n_err++; $display("FAIL b2b_block%0d: got %0d bad words, %0d cycles want 0, 192", b, errs, exp_cycles); end
    end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) rf[i] = 0;
    test_reset();
    test_abc();
    test_sweep();
    test_stall();
    test_reset_mid();
    test_start_release();
    test_perf();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
